// File: rtl/scpu_mdu.sv
// Iterative multiply/divide unit with HI/LO registers: shift-add multiply, restoring divide.
// Define SCPU_MDU_MADD_EN to enable the MADD/MSUB accumulate ops (6/7).
module scpu_mdu #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MADD  = 3'd6,
        OP_MSUB  = 3'd7
    } op_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    op_t                 op_q, op_d;
    logic                sign_a_q, sign_a_d;
    logic                sign_b_q, sign_b_d;
    logic [DATA_W-1:0]   mag_b_q, mag_b_d;
    logic [DATA_W-1:0]   a_raw_q, a_raw_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                done_q, done_d;

    op_t                 op_in;
    logic                signed_in;
    logic                calc_in;
    logic                is_div;
    logic [DATA_W-1:0]   mag_a_in;
    logic [DATA_W-1:0]   mag_b_in;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_diff;
    logic [2*DATA_W-1:0] prod_s;
    logic [DATA_W-1:0]   quo_s;
    logic [DATA_W-1:0]   rem_s;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        mag_b_d  = mag_b_q;
        a_raw_d  = a_raw_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        op_in     = op_t'(op);
        signed_in = (op_in == OP_MULT) || (op_in == OP_DIV) ||
                    (op_in == OP_MADD) || (op_in == OP_MSUB);
`ifdef SCPU_MDU_MADD_EN
        calc_in   = (op_in != OP_MTHI) && (op_in != OP_MTLO);
`else
        calc_in   = (op_in == OP_MULT) || (op_in == OP_MULTU) ||
                    (op_in == OP_DIV)  || (op_in == OP_DIVU);
`endif
        mag_a_in  = (signed_in && a[DATA_W-1]) ? -a : a;
        mag_b_in  = (signed_in && b[DATA_W-1]) ? -b : b;
        is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);

        // Multiply: low half holds the multiplier, product grows in from the top.
        mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
        // Divide: high half is the partial remainder, low half shifts the dividend out.
        div_diff  = acc_q[2*DATA_W-1:DATA_W-1] - {1'b0, mag_b_q};

        prod_s    = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        quo_s     = (sign_a_q ^ sign_b_q) ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
        rem_s     = sign_a_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (calc_in) begin
                        state_d  = S_CALC;
                        count_d  = CNT_W'(DATA_W);
                        op_d     = op_in;
                        sign_a_d = signed_in & a[DATA_W-1];
                        sign_b_d = signed_in & b[DATA_W-1];
                        mag_b_d  = mag_b_in;
                        a_raw_d  = a;
                        acc_d    = {{DATA_W{1'b0}}, mag_a_in};
                    end else if (op_in == OP_MTHI) begin
                        hi_d = a;
                    end else if (op_in == OP_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            S_CALC: begin
                count_d = count_q - 1'b1;
                if (is_div) begin
                    if (!div_diff[DATA_W])
                        acc_d = {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
                    else
                        acc_d = {acc_q[2*DATA_W-2:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[DATA_W-1:1]};
                end
                if (count_q == CNT_W'(1))
                    state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                case (op_q)
                    OP_DIV, OP_DIVU: begin
                        if (mag_b_q == '0) begin
                            lo_d = '1;
                            hi_d = a_raw_q;
                        end else begin
                            lo_d = quo_s;
                            hi_d = rem_s;
                        end
                    end
`ifdef SCPU_MDU_MADD_EN
                    OP_MADD: {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
                    OP_MSUB: {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
`endif
                    default: {hi_d, lo_d} = prod_s;
                endcase
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            op_q     <= OP_MULT;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            mag_b_q  <= '0;
            a_raw_q  <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            mag_b_q  <= mag_b_d;
            a_raw_q  <= a_raw_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_scpu_mdu.sv
// Self-checking bench for scpu_mdu against an arithmetic HI/LO reference model.
module tb_scpu_mdu;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    scpu_mdu #(.DATA_W(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .hi   (hi),
        .lo   (lo)
    );

    always #5 clk = ~clk;

    // Returns the expected {hi,lo} after an iterative op, given the current {hi,lo}.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                          input logic [31:0] y, input logic [63:0] acc);
        longint      sx, sy;
        int          ix, iy;
        logic [63:0] r;
        sx = $signed(x);
        sy = $signed(y);
        ix = $signed(x);
        iy = $signed(y);
        r  = acc;
        case (o)
            3'd0: r = sx * sy;
            3'd1: r = {32'd0, x} * {32'd0, y};
            3'd2: begin
                if (y == 32'd0)
                    r = {x, 32'hFFFF_FFFF};
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
                    r = {32'd0, 32'h8000_0000};
                else begin
                    r[31:0]  = ix / iy;
                    r[63:32] = ix % iy;
                end
            end
            3'd3: r = (y == 32'd0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
            3'd6: r = acc + sx * sy;
            3'd7: r = acc - sx * sy;
            default: r = acc;
        endcase
        return r;
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit now, input bit inject, input string tag);
        int          n;
        logic [63:0] expv;
        expv = model(o, x, y, {m_hi, m_lo});
        if (!now) @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            if (inject && n == 4) begin start = 1'b1; op = 3'd0; a = $urandom; b = $urandom; end
            if (inject && n == 5) begin op = 3'd4; a = 32'd5; end
            if (inject && n == 6) start = 1'b0;
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        n_cmp++;
        if (n != 33) begin
            n_bad++;
            $display("FAIL %s busy_len: got %0d expected 33", tag, n);
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL %s done: got %b expected 1", tag, done);
        end
        n_cmp++;
        if ({hi, lo} !== expv) begin
            n_bad++;
            $display("FAIL %s hilo: got %h_%h expected %h", tag, hi, lo, expv);
        end
        {m_hi, m_lo} = expv;
    endtask

    task automatic move_to(input logic [2:0] o, input logic [31:0] x, input string tag);
        @(negedge clk);
        start = 1'b1; op = o; a = x;
        @(negedge clk);
        start = 1'b0;
        if (o == 3'd4) m_hi = x; else m_lo = x;
        n_cmp++;
        if ({busy, done, hi, lo} !== {2'b00, m_hi, m_lo}) begin
            n_bad++;
            $display("FAIL %s: got busy=%b done=%b %h_%h expected busy=0 done=0 %h_%h",
                     tag, busy, done, hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            n_bad++;
            $display("FAIL reset_init: got busy=%b done=%b %h_%h expected all 0", busy, done, hi, lo);
        end
        rstn = 1'b1;
        move_to(3'd4, 32'h1234_5678, "rst_mthi");
        move_to(3'd5, 32'h9ABC_DEF0, "rst_mtlo");
        start = 1'b1; op = 3'd2; a = 32'd1000; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        m_hi = '0; m_lo = '0;
        n_cmp++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            n_bad++;
            $display("FAIL reset_mid_div: got busy=%b done=%b %h_%h expected all 0", busy, done, hi, lo);
        end
        repeat (40) @(negedge clk);
        n_cmp++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            n_bad++;
            $display("FAIL reset_abort: got busy=%b done=%b %h_%h expected all 0", busy, done, hi, lo);
        end
    endtask

    task automatic test_mult();
        run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0, "mult_m3x7");
        n_cmp++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            n_bad++;
            $display("FAIL mult_m3x7_const: got %h_%h expected ffffffff_ffffffeb", hi, lo);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL done_pulse: got %b expected 0", done);
        end
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "multu_max");
        n_cmp++;
        if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
            n_bad++;
            $display("FAIL multu_max_const: got %h_%h expected fffffffe_00000001", hi, lo);
        end
        run_op(3'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, "mult_minmin");
        for (int i = 0; i < 8; i++)
            run_op(3'($urandom_range(0, 1)), $urandom, $urandom, 1'b0, 1'b0, "mult_rand");
    endtask

    task automatic test_div();
        logic [31:0] x, y;
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, "div_m7d2");
        n_cmp++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            n_bad++;
            $display("FAIL div_m7d2_const: got %h_%h expected ffffffff_fffffffd", hi, lo);
        end
        run_op(3'd3, 32'd7, 32'd0, 1'b0, 1'b0, "divu_by0");
        n_cmp++;
        if ({hi, lo} !== 64'h0000_0007_FFFF_FFFF) begin
            n_bad++;
            $display("FAIL divu_by0_const: got %h_%h expected 00000007_ffffffff", hi, lo);
        end
        run_op(3'd2, 32'hFFFF_FF00, 32'd0, 1'b0, 1'b0, "div_by0");
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "div_ovf");
        n_cmp++;
        if ({hi, lo} !== 64'h0000_0000_8000_0000) begin
            n_bad++;
            $display("FAIL div_ovf_const: got %h_%h expected 00000000_80000000", hi, lo);
        end
        for (int i = 0; i < 10; i++) begin
            x = $urandom;
            y = (i % 2 == 0) ? 32'($signed(5'($urandom))) : $urandom;
            run_op(3'($urandom_range(2, 3)), x, y, 1'b0, 1'b0, "div_rand");
        end
    endtask

    task automatic test_ignore();
        run_op(3'd2, 32'd100, 32'hFFFF_FFFD, 1'b0, 1'b1, "div_ignore");
        move_to(3'd4, 32'd5, "mthi_idle");
        move_to(3'd5, $urandom, "mtlo_idle");
    endtask

    task automatic test_back_to_back();
        run_op(3'd1, $urandom, $urandom, 1'b0, 1'b0, "b2b_first");
        run_op(3'd2, $urandom, 32'd13, 1'b1, 1'b0, "b2b_second");
        run_op(3'd0, $urandom, $urandom, 1'b1, 1'b0, "b2b_third");
    endtask

`ifdef SCPU_MDU_MADD_EN
    task automatic test_madd();
        move_to(3'd4, 32'd0, "madd_sethi");
        move_to(3'd5, 32'd10, "madd_setlo");
        run_op(3'd6, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, "madd_dir");
        n_cmp++;
        if ({hi, lo} !== 64'h0000_0000_0000_0004) begin
            n_bad++;
            $display("FAIL madd_const: got %h_%h expected 00000000_00000004", hi, lo);
        end
        run_op(3'd7, 32'd1, 32'd5, 1'b0, 1'b0, "msub_dir");
        n_cmp++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_bad++;
            $display("FAIL msub_const: got %h_%h expected ffffffff_ffffffff", hi, lo);
        end
        for (int i = 0; i < 6; i++)
            run_op(3'($urandom_range(6, 7)), $urandom, $urandom, 1'b0, 1'b0, "madd_rand");
    endtask
`else
    task automatic test_madd();
        move_to(3'd4, 32'hCAFE_0001, "noop_sethi");
        move_to(3'd5, 32'hBEEF_0002, "noop_setlo");
        for (int k = 6; k < 8; k++) begin
            @(negedge clk);
            start = 1'b1; op = 3'(k); a = $urandom; b = $urandom;
            @(negedge clk);
            start = 1'b0;
            n_cmp++;
            if (busy !== 1'b0) begin
                n_bad++;
                $display("FAIL noop_busy op%0d: got %b expected 0", k, busy);
            end
            repeat (3) @(negedge clk);
            n_cmp++;
            if ({busy, done, hi, lo} !== {2'b00, m_hi, m_lo}) begin
                n_bad++;
                $display("FAIL noop_state op%0d: got busy=%b done=%b %h_%h expected busy=0 done=0 %h_%h",
                         k, busy, done, hi, lo, m_hi, m_lo);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_ignore();
        test_back_to_back();
        test_madd();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
